sync_fifo_gen2: RTL and testbench
=================================

SYNC_FIFO_GEN2 -- requirements
Module: sync_fifo_gen2

Interface
REQ-001 Parameter DATA_W, 128, data width in bits.
REQ-002 Parameter DEPTH, 16, number of entries; power of 2, >= 4.
REQ-003 Parameter AF_LVL, DEPTH-2, almost-full threshold in entries.
REQ-004 Parameter AE_LVL, 2, almost-empty threshold in entries.
REQ-005 Parameter FWFT, 0, 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 Illegal parameters SHALL fail elaboration: DEPTH not power of 2 or < 4, or not (1 <= AE_LVL < AF_LVL <= DEPTH-1).
REQ-007 clk  input  1  single clock; all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 i_wren  input  1  write request.
REQ-010 i_wrdata  input  DATA_W  write data.
REQ-011 i_rden  input  1  read request (pop).
REQ-012 i_clr_err  input  1  clears sticky error flags.
REQ-013 o_rddata  output  DATA_W  read data.
REQ-014 o_rdvalid  output  1  o_rddata valid.
REQ-015 o_full / o_alm_full  output  1 each  full / almost-full flags.
REQ-016 o_empty / o_alm_empty  output  1 each  empty / almost-empty flags.
REQ-017 o_count  output  $clog2(DEPTH)+1  current occupancy.
REQ-018 o_overflow / o_underflow  output  1 each  sticky error flags.

Function
REQ-019 Write accepted iff i_wren && !o_full; read accepted iff i_rden && !o_empty; both evaluated on pre-edge state.
REQ-020 Accepted write stores i_wrdata at write pointer; pointer increments, wraps DEPTH-1 -> 0.
REQ-021 Accepted read advances read pointer, same wrap rule; data order strictly FIFO.
REQ-022 o_count: +1 write only, -1 read only, unchanged both or neither; never exceeds DEPTH or goes below 0.
REQ-023 All flags registered, reflecting post-edge count: o_full = (count==DEPTH), o_empty = (count==0), o_alm_full = (count>=AF_LVL), o_alm_empty = (count<=AE_LVL).
REQ-024 FWFT=0: on accepted read, o_rddata loads head entry at that edge, o_rdvalid = 1 for the following cycle only; otherwise o_rdvalid = 0, o_rddata holds last value.
REQ-025 FWFT=1: o_rddata = head entry and o_rdvalid = !o_empty continuously; first write into empty FIFO visible the cycle after the write edge; i_rden pops.
REQ-026 i_wren while o_full: data dropped, no pointer/count change, o_overflow set at next edge.
REQ-027 i_rden while o_empty: no state change, o_rdvalid stays 0, o_underflow set at next edge.
REQ-028 Error flags remain set until an edge with i_clr_err=1; a new error in the same cycle as i_clr_err wins (flag stays 1).
REQ-029 Simultaneous write and read when full: read accepted, write dropped with overflow; when empty: write accepted, read ignored with underflow.

Reset
REQ-030 reset=0 SHALL immediately, without clock edge, force: pointers 0, o_count 0, o_empty 1, o_alm_empty 1, o_full 0, o_alm_full 0, o_rdvalid 0, o_rddata 0, o_overflow 0, o_underflow 0.
REQ-031 Storage array is not reset; contents unobservable until rewritten.
REQ-032 Reset asserted mid-operation discards all entries; first write after release lands at index 0.

Verification
REQ-033 Defaults, write 0..16 on consecutive cycles -> count 1..16, o_alm_full rises at count 14, o_full at 16, 17th write -> o_overflow=1, count stays 16.
REQ-034 From full, FWFT=0, 17 consecutive reads -> o_rddata 0..15 each one cycle after read with o_rdvalid=1, o_empty after 16th, 17th -> o_underflow=1, o_rdvalid=0.
REQ-035 At count 8, simultaneous read+write for 40 cycles -> count stays 8, pointers wrap twice, output sequence equals input sequence delayed by 8 entries.
REQ-036 FWFT=1, single write 0xA5 into empty -> next cycle o_empty=0, o_rdvalid=1, o_rddata=0xA5 with no read; one read -> o_empty=1, o_rdvalid=0.
REQ-037 At count 10, drive reset=0 between clock edges -> all outputs reach REQ-030 values before next edge; after release write 0x1 then read -> 0x1.
REQ-038 o_overflow=1, i_clr_err=1 with write while full same cycle -> o_overflow stays 1; next cycle i_clr_err=1 alone -> o_overflow=0.

Source files
------------

// File: rtl/sync_fifo_gen2.sv
// Synchronous FIFO with registered status flags, sticky overflow/underflow flags
// and a choice of registered-read or first-word-fall-through output.
module sync_fifo_gen2 #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2,
    parameter int FWFT   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wren,
    input  logic [DATA_W-1:0]        i_wrdata,
    input  logic                     i_rden,
    input  logic                     i_clr_err,
    output logic [DATA_W-1:0]        o_rddata,
    output logic                     o_rdvalid,
    output logic                     o_full,
    output logic                     o_alm_full,
    output logic                     o_empty,
    output logic                     o_alm_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_gen2: DEPTH must be a power of 2 and at least 4");
    end
    if (!((AE_LVL >= 1) && (AE_LVL < AF_LVL) && (AF_LVL <= DEPTH - 1))) begin : g_bad_levels
        $error("sync_fifo_gen2: thresholds must satisfy 1 <= AE_LVL < AF_LVL <= DEPTH-1");
    end
    if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
        $error("sync_fifo_gen2: FWFT must be 0 or 1");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wrPtr_q, wrPtr_d;
    logic [AW-1:0]     rdPtr_q, rdPtr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, almFull_q, empty_q, almEmpty_q;
    logic              ovf_q, unf_q;
    logic              wrAcc, rdAcc;

    // Acceptance uses the pre-edge flags, so a full FIFO can still pop and an
    // empty one can still push in the same cycle.
    always_comb begin
        wrAcc   = i_wren && !full_q;
        rdAcc   = i_rden && !empty_q;
        wrPtr_d = wrAcc ? wrPtr_q + AW'(1) : wrPtr_q;
        rdPtr_d = rdAcc ? rdPtr_q + AW'(1) : rdPtr_q;
        count_d = count_q;
        if (wrAcc && !rdAcc) begin
            count_d = count_q + CW'(1);
        end else if (rdAcc && !wrAcc) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            almFull_q  <= 1'b0;
            empty_q    <= 1'b1;
            almEmpty_q <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            full_q     <= (count_d == DEPTH_C);
            almFull_q  <= (count_d >= AF_C);
            empty_q    <= (count_d == '0);
            almEmpty_q <= (count_d <= AE_C);
            // A fresh error outranks a clear in the same cycle.
            ovf_q      <= (i_wren && full_q) || (ovf_q && !i_clr_err);
            unf_q      <= (i_rden && empty_q) || (unf_q && !i_clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (wrAcc) begin
            mem_q[wrPtr_q] <= i_wrdata;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Gated so the output is zero, not stale storage, whenever nothing is queued.
        assign o_rddata  = empty_q ? '0 : mem_q[rdPtr_q];
        assign o_rdvalid = !empty_q;
    end else begin : g_regread
        logic [DATA_W-1:0] rdData_q;
        logic              rdValid_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rdData_q  <= '0;
                rdValid_q <= 1'b0;
            end else begin
                rdValid_q <= rdAcc;
                if (rdAcc) begin
                    rdData_q <= mem_q[rdPtr_q];
                end
            end
        end

        assign o_rddata  = rdData_q;
        assign o_rdvalid = rdValid_q;
    end

    assign o_count     = count_q;
    assign o_full      = full_q;
    assign o_alm_full  = almFull_q;
    assign o_empty     = empty_q;
    assign o_alm_empty = almEmpty_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

endmodule

// File: tb/tb_sync_fifo_gen2.sv
// Scoreboard bench for sync_fifo_gen2: one registered-read and one FWFT instance
// share stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_gen2;

    localparam int DATA_W = 128;
    localparam int DEPTH  = 16;
    localparam int AF_LVL = 14;
    localparam int AE_LVL = 2;

    logic              clk    = 1'b0;
    logic              rst_n  = 1'b0;
    logic              wren   = 1'b0;
    logic              rden   = 1'b0;
    logic              clrErr = 1'b0;
    logic [DATA_W-1:0] wrData = '0;

    logic [DATA_W-1:0] rData, fData;
    logic              rValid, rFull, rAlmFull, rEmpty, rAlmEmpty, rOvf, rUnf;
    logic              fValid, fFull, fAlmFull, fEmpty, fAlmEmpty, fOvf, fUnf;
    logic [4:0]        rCount, fCount;

    int checks = 0;
    int fails  = 0;

    sync_fifo_gen2 #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL), .FWFT(0)) dutReg (
        .clk(clk), .reset(rst_n), .i_wren(wren), .i_wrdata(wrData), .i_rden(rden),
        .i_clr_err(clrErr), .o_rddata(rData), .o_rdvalid(rValid), .o_full(rFull),
        .o_alm_full(rAlmFull), .o_empty(rEmpty), .o_alm_empty(rAlmEmpty), .o_count(rCount),
        .o_overflow(rOvf), .o_underflow(rUnf)
    );

    sync_fifo_gen2 #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL), .FWFT(1)) dutFwft (
        .clk(clk), .reset(rst_n), .i_wren(wren), .i_wrdata(wrData), .i_rden(rden),
        .i_clr_err(clrErr), .o_rddata(fData), .o_rdvalid(fValid), .o_full(fFull),
        .o_alm_full(fAlmFull), .o_empty(fEmpty), .o_alm_empty(fAlmEmpty), .o_count(fCount),
        .o_overflow(fOvf), .o_underflow(fUnf)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue holding the stored words plus sticky error bits.
    logic [DATA_W-1:0] modelQ [$];
    logic [DATA_W-1:0] expRdQ [$];
    logic [DATA_W-1:0] lastRd   = '0;
    logic              modelOvf = 1'b0;
    logic              modelUnf = 1'b0;
    int                preSize;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modelQ.delete();
            expRdQ.delete();
            lastRd   = '0;
            modelOvf = 1'b0;
            modelUnf = 1'b0;
        end else begin
            preSize  = modelQ.size();
            modelOvf = (wren && preSize == DEPTH) || (modelOvf && !clrErr);
            modelUnf = (rden && preSize == 0) || (modelUnf && !clrErr);
            if (rden && preSize > 0) begin
                lastRd = modelQ.pop_front();
                expRdQ.push_back(lastRd);
            end
            if (wren && preSize < DEPTH) begin
                modelQ.push_back(wrData);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic checkStatus(input string tag, input logic [4:0] cnt, input logic full,
                               input logic af, input logic empty, input logic ae,
                               input logic ovf, input logic unf);
        int sz;
        sz = modelQ.size();
        checkOutput({tag, "_count"}, DATA_W'(cnt), DATA_W'(sz));
        checkOutput({tag, "_full"}, DATA_W'(full), DATA_W'(sz == DEPTH));
        checkOutput({tag, "_alm_full"}, DATA_W'(af), DATA_W'(sz >= AF_LVL));
        checkOutput({tag, "_empty"}, DATA_W'(empty), DATA_W'(sz == 0));
        checkOutput({tag, "_alm_empty"}, DATA_W'(ae), DATA_W'(sz <= AE_LVL));
        checkOutput({tag, "_overflow"}, DATA_W'(ovf), DATA_W'(modelOvf));
        checkOutput({tag, "_underflow"}, DATA_W'(unf), DATA_W'(modelUnf));
    endtask

    // Monitor: compares both instances on the falling edge, away from state updates.
    always @(negedge clk) begin
        logic [DATA_W-1:0] expWord;
        checkStatus("reg", rCount, rFull, rAlmFull, rEmpty, rAlmEmpty, rOvf, rUnf);
        checkStatus("fwft", fCount, fFull, fAlmFull, fEmpty, fAlmEmpty, fOvf, fUnf);
        checkOutput("reg_rdvalid", DATA_W'(rValid), DATA_W'(expRdQ.size() != 0));
        checkOutput("reg_rddata_hold", rData, lastRd);
        if (expRdQ.size() != 0) begin
            expWord = expRdQ.pop_front();
            if (rValid) begin
                checkOutput("reg_rddata", rData, expWord);
            end
        end
        checkOutput("fwft_rdvalid", DATA_W'(fValid), DATA_W'(modelQ.size() != 0));
        if (modelQ.size() != 0) begin
            checkOutput("fwft_rddata", fData, modelQ[0]);
        end
    end

    task automatic applyStimulus(input logic w, input logic r, input logic [DATA_W-1:0] d,
                                 input logic c);
        @(negedge clk);
        wren   = w;
        rden   = r;
        wrData = d;
        clrErr = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0);
    endtask

    function automatic logic [DATA_W-1:0] randWord();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic resetCheck(input string tag);
        checkOutput({tag, "_reg_count"}, DATA_W'(rCount), '0);
        checkOutput({tag, "_reg_empty"}, DATA_W'(rEmpty), DATA_W'(1));
        checkOutput({tag, "_reg_alm_empty"}, DATA_W'(rAlmEmpty), DATA_W'(1));
        checkOutput({tag, "_reg_full"}, DATA_W'(rFull), '0);
        checkOutput({tag, "_reg_alm_full"}, DATA_W'(rAlmFull), '0);
        checkOutput({tag, "_reg_rdvalid"}, DATA_W'(rValid), '0);
        checkOutput({tag, "_reg_rddata"}, rData, '0);
        checkOutput({tag, "_reg_errs"}, DATA_W'({rOvf, rUnf}), '0);
        checkOutput({tag, "_fwft_count"}, DATA_W'(fCount), '0);
        checkOutput({tag, "_fwft_empty"}, DATA_W'(fEmpty), DATA_W'(1));
        checkOutput({tag, "_fwft_rdvalid"}, DATA_W'(fValid), '0);
        checkOutput({tag, "_fwft_rddata"}, fData, '0);
        checkOutput({tag, "_fwft_errs"}, DATA_W'({fOvf, fUnf}), '0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        resetCheck("por");
        #2 rst_n = 1'b1;

        // Fill past full with an incrementing pattern, then drain past empty.
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'b0, DATA_W'(i), 1'b0);
        for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b1, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);

        // Steady half-full streaming; pointers wrap repeatedly.
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, randWord(), 1'b0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, randWord(), 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, '0, 1'b0);

        // Overflow stickiness against a same-cycle clear.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, randWord(), 1'b0);
        applyStimulus(1'b1, 1'b0, randWord(), 1'b0);
        applyStimulus(1'b1, 1'b0, randWord(), 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 1'b1, randWord(), 1'b0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, randWord(), 1'b0);
        applyStimulus(1'b0, 1'b1, '0, 1'b1);

        // Single word into an empty FIFO, visible on the FWFT port without a read.
        applyStimulus(1'b1, 1'b0, DATA_W'(8'hA5), 1'b0);
        idle(2);
        applyStimulus(1'b0, 1'b1, '0, 1'b0);
        idle(2);

        // Asynchronous reset mid-operation at count 10.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, randWord(), 1'b0);
        @(negedge clk);
        wren = 1'b0;
        rden = 1'b0;
        #2 rst_n = 1'b0;
        #1 resetCheck("async");
        @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, DATA_W'(1), 1'b0);
        applyStimulus(1'b0, 1'b1, '0, 1'b0);
        idle(2);

        // Random traffic: write-heavy, then read-heavy, then balanced.
        for (int i = 0; i < 600; i++) begin
            int wBias;
            wBias = (i < 200) ? 75 : (i < 400) ? 25 : 50;
            applyStimulus($urandom_range(0, 99) < wBias, $urandom_range(0, 99) < (100 - wBias),
                          randWord(), $urandom_range(0, 15) == 0);
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
